sreg_fifo: RTL and testbench
============================

Name: sreg_fifo

Overview:
- Synchronous FIFO directly downstream of the 4-bit shift register.
- Buffers the `sout` nibble stream so a slower consumer can drain it with a valid/ready handshake.
- Reports occupancy and flags data dropped while full.
- Single clock domain; first-word-fall-through output.

Parameters:
- DATA_W, 4, width of each entry (matches shift-register `sout`).
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- ADDR_W, 3, log2(DEPTH); derived, not overridden independently.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  write data, driven by shift-register `sout`.
- in_valid  input  1  write request.
- in_ready  output  1  FIFO can accept; equals !full.
- out_data  output  DATA_W  head entry (FWFT); holds the last head value when empty.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer accepts the head entry.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a write was attempted while full.
- clr_ovf  input  1  clears `overflow` and `drop_cnt`.
- drop_cnt  output  8  saturating count of rejected writes.

Behaviour:
- Reset (reset==0 at a rising clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, in_ready=1, out_valid=0.
  - overflow=0, drop_cnt=0, out_data=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data on that edge.
- Push:
  - Occurs when in_valid && in_ready.
  - Writes mem[wr_ptr] and advances wr_ptr modulo DEPTH (natural ADDR_W-bit wrap).
- Pop:
  - Occurs when out_valid && out_ready.
  - Advances rd_ptr modulo DEPTH.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N when the FIFO was empty (visible in cycle N+1).
- out_data is mem[rd_ptr], read combinationally from the register array.
- Count update per edge:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- Simultaneous push and pop:
  - Both happen only when 0 < count < DEPTH.
  - When full, in_ready=0, so the write is rejected even if a pop occurs in the same cycle. There is no combinational path from out_ready to in_ready.
  - When empty, out_valid=0, so no pop occurs; the push proceeds.
- Rejected write (in_valid && !in_ready):
  - Sets overflow=1 on the next edge.
  - Increments drop_cnt, saturating at 255.
  - FIFO contents and pointers are unchanged.
- clr_ovf=1:
  - Clears overflow and drop_cnt on the edge.
  - If a rejected write occurs on the same edge, the set wins: overflow=1, drop_cnt=1.
- Stability: out_data and out_valid change only on clk edges; no output depends combinationally on in_valid or out_ready.
- full, empty and in_ready are registered or decoded from registered count; no glitch paths.
- Illegal DEPTH (not a power of two): elaboration-time error via a generate check.

Decomposition:
- Shared package `sreg_pkg`:
  - SREG_DATA_W=4.
  - SREG_FIFO_DEPTH=8.
  - SREG_DROP_MAX=8'hFF.
  - Used by the shift register, this FIFO and their benches.
- One sub-module, `sreg_fifo_mem`:
  - DEPTH×DATA_W register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset.
- Pointer, count and flag logic stays in sreg_fifo.

Test Plan:
- Reset, then idle -> count=0, empty=1, full=0, in_ready=1, out_valid=0, overflow=0, drop_cnt=0.
- Push 4'h1 (out_ready=0) for one cycle -> next cycle out_valid=1, out_data=4'h1, count=1; assert out_ready for one cycle -> empty=1, count=0.
- Push 4'h0..4'h7 back-to-back with out_ready=0 -> full=1, in_ready=0, count=8; then drain with out_ready=1 -> out_data sequence 0,1,…,7, then empty=1.
- Full FIFO, in_valid=1 with 4'hA for 3 cycles -> overflow=1, drop_cnt=3, contents still 0..7; then clr_ovf=1 for one cycle -> overflow=0, drop_cnt=0.
- Steady stream with count=3, in_valid=1 and out_ready=1 for 20 cycles (data incrementing mod 16, as produced by the shift-register bench) -> count stays 3; outputs are in order across pointer wrap-around; no drops.
- FIFO holding 5 entries, reset=0 for one edge while in_valid=1 -> count=0, empty=1; the entry offered during reset is not stored.

Source files
------------

// File: rtl/sreg_pkg.sv
// Shared definitions for the 4-bit shift register, its downstream FIFO and their benches.
package sreg_pkg;

    // Nibble width produced by the shift register `sout`.
    localparam int SREG_DATA_W = 4;

    // Default FIFO depth; must be a power of two and at least 2.
    localparam int SREG_FIFO_DEPTH = 8;

    // Saturation value of the rejected-write counter.
    localparam logic [7:0] SREG_DROP_MAX = 8'hFF;

    // Per-edge FIFO operation, encoded as {pop, push}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // True when n is a power of two no smaller than 2 (legal FIFO depth).
    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sreg_fifo_mem.sv
// Register-array storage for sreg_fifo: one synchronous write port, one
// asynchronous read port, no reset (contents survive a FIFO reset).
module sreg_fifo_mem
    import sreg_pkg::*;
#(
    parameter  int DATA_W = SREG_DATA_W,
    parameter  int DEPTH  = SREG_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: store wdata at waddr on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sreg_fifo.sv
// First-word-fall-through FIFO buffering the shift-register nibble stream.
// Tracks occupancy, rejects writes while full and records them in a sticky
// overflow flag plus a saturating drop counter.
module sreg_fifo
    import sreg_pkg::*;
#(
    parameter  int DATA_W = SREG_DATA_W,
    parameter  int DEPTH  = SREG_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [7:0]        drop_cnt
);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("sreg_fifo: DEPTH must be a power of two and at least 2");
    end

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q,   drop_d;
    logic [DATA_W-1:0] last_q,   last_d;

    logic              full_w;
    logic              empty_w;
    logic              push;
    logic              pop;
    logic              reject;
    logic              mem_we;
    logic [DATA_W-1:0] head;
    fifo_op_e          op;

    // Flags decode only from the registered count, so they never glitch
    // and in_ready has no path from out_ready.
    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    assign push   = in_valid && !full_w;
    assign pop    = out_ready && !empty_w;
    assign reject = in_valid && full_w;
    assign op     = fifo_op_e'({pop, push});

    // Writes offered on a reset edge must not land in the array.
    assign mem_we = push && reset;

    sreg_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case (op)
            FIFO_PUSH: count_d = count_q + CNT_ONE;
            FIFO_POP:  count_d = count_q - CNT_ONE;
            default:   count_d = count_q;
        endcase
    end

    // Overflow / drop-counter next-state; a same-edge rejected write beats the clear.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (reject) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_d = 8'd1;
            end else if (drop_q != SREG_DROP_MAX) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    // Remember each popped head so out_data can hold it once the FIFO empties;
    // the array slot under rd_ptr after the last pop is stale, not the last head.
    always_comb begin
        last_d = last_q;
        if (pop) begin
            last_d = head;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            last_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            last_q     <= last_d;
        end
    end

    assign in_ready  = !full_w;
    assign out_valid = !empty_w;
    assign out_data  = empty_w ? last_q : head;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

    // Occupancy never exceeds DEPTH and always equals the pointer distance.
    a_count_range : assert property (@(posedge clk) disable iff (!reset)
        count_q <= DEPTH_CNT);
    a_ptr_dist : assert property (@(posedge clk) disable iff (!reset)
        (wr_ptr_q - rd_ptr_q) == count_q[ADDR_W-1:0]);

endmodule

// File: tb/tb_sreg_fifo.sv
// Self-checking bench for sreg_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_sreg_fifo;
    import sreg_pkg::*;

    localparam int DEPTH = SREG_FIFO_DEPTH;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf = 1'b0;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [3:0] mq[$];
    bit       m_ovf  = 1'b0;
    int       m_drop = 0;
    bit [3:0] m_last = '0;

    always #5 clk = ~clk;

    sreg_fifo #(
        .DATA_W (SREG_DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = mq.size();
        check("count",     32'(count),     32'(n));
        check("empty",     32'(empty),     32'(n == 0));
        check("full",      32'(full),      32'(n == DEPTH));
        check("in_ready",  32'(in_ready),  32'(n != DEPTH));
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("out_data",  32'(out_data),  32'((n != 0) ? mq[0] : m_last));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input logic rst_n, input logic iv, input logic [3:0] d,
                         input logic ordy, input logic clr);
        bit push_ok, pop_ok, rej;
        reset     = rst_n;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clr_ovf   = clr;
        push_ok = iv && (mq.size() < DEPTH);
        pop_ok  = ordy && (mq.size() > 0);
        rej     = iv && (mq.size() == DEPTH);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            m_last = '0;
        end else begin
            if (pop_ok)  m_last = mq.pop_front();
            if (push_ok) mq.push_back(d);
            if (rej) begin
                m_ovf  = 1'b1;
                m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bit [3:0] d;
        int pv, pr;

        // Reset and idle
        cycle(0, 0, 4'h0, 0, 0);
        cycle(0, 0, 4'h0, 0, 0);
        cycle(1, 0, 4'h0, 0, 0);
        cycle(1, 0, 4'h0, 0, 0);

        // Single push then pop
        cycle(1, 1, 4'h1, 0, 0);
        cycle(1, 0, 4'h0, 1, 0);
        cycle(1, 0, 4'h0, 0, 0);

        // Fill 0..7, reject three writes of A, clear, then drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 4'(i), 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 4'hA, 0, 0);
        check("drops_after_3", 32'(drop_cnt), 32'd3);
        cycle(1, 0, 4'h0, 0, 1);
        // Full with out_ready: write still rejected even though a pop happens
        cycle(1, 1, 4'hB, 1, 0);
        cycle(1, 0, 4'h0, 0, 1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 4'h0, 1, 0);

        // Steady stream at depth 3 across pointer wrap
        d = 4'h0;
        for (int i = 0; i < 3; i++) begin cycle(1, 1, d, 0, 0); d = d + 4'h1; end
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, d, 1, 0);
            check("steady_count", 32'(count), 32'd3);
            d = d + 4'h1;
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 4'h0, 1, 0);

        // Reset with 5 entries stored and a write offered on the reset edge
        for (int i = 0; i < 5; i++) cycle(1, 1, 4'(i + 9), 0, 0);
        cycle(0, 1, 4'hF, 0, 0);
        cycle(1, 0, 4'h0, 0, 0);

        // Drop counter saturation, then a clear colliding with a rejected write
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 4'(i), 0, 0);
        for (int i = 0; i < 260; i++) cycle(1, 1, 4'hC, 0, 0);
        check("drops_saturate", 32'(drop_cnt), 32'd255);
        cycle(1, 1, 4'hC, 0, 1);
        check("clr_vs_reject", 32'(drop_cnt), 32'd1);
        cycle(1, 0, 4'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 4'h0, 1, 0);

        // Random traffic with varying push/pop pressure
        for (int seg = 0; seg < 12; seg++) begin
            pv = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int i = 0; i < 60; i++) begin
                cycle(($urandom_range(199) != 0),
                      ($urandom_range(99) < pv),
                      4'($urandom),
                      ($urandom_range(99) < pr),
                      ($urandom_range(39) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
